sprite_rom_arbiter: RTL and testbench
=====================================

# sprite_rom_arbiter

Round-robin arbiter that shares one synchronous sprite ROM between N_REQ pixel-pipeline requesters (e.g. duck, dog, crosshair renderers). It accepts one read per cycle, drives the ROM address port, and tracks each in-flight read with a fixed-latency tag pipeline. Returned ROM data is flagged to the requester that issued the read. It sits between the sprite draw stages and the shared ROM instance, ahead of the pixel mux.

## Interface
- N_REQ, 3, number of requesters (≥1)
- ADDR_W, 12, ROM address width
- DATA_W, 12, ROM data width (RGB444)
- ROM_LAT, 2, ROM read latency in clocks from registered address to valid data (≥1)

- clk  in  1  posedge clock
- rst  in  1  reset, asynchronous, active-high
- req  in  N_REQ  read request per requester, level
- addr  in  N_REQ*ADDR_W  request addresses; requester i at bits [i*ADDR_W +: ADDR_W]
- gnt  out  N_REQ  one-hot acknowledge, combinational
- rom_en  out  1  ROM read enable, registered
- rom_addr  out  ADDR_W  ROM address, registered
- rom_data  in  DATA_W  ROM read data
- rvalid  out  N_REQ  one-hot return strobe, aligned with rdata
- rdata  out  DATA_W  returned data; equals rom_data, meaningful only while rvalid≠0

## Operation
- Pointer ptr (clog2(N_REQ) bits, min 1) holds the highest-priority index.
- gnt: winner w = first i with req[i]=1, scanning ptr, ptr+1, … wrapping N_REQ-1→0; gnt=onehot(w); gnt=0 when req=0. Pure function of req and ptr.
- Transfer: a read is accepted at the clock edge where req[w]&gnt[w]=1. A requester holding req keeps addr stable until that edge; it may keep req high to stream consecutive reads.
- On accept: rom_addr←addr[w], rom_en←1, ptr←(w+1) mod N_REQ, tag stage 0 ← {valid=1, idx=w}.
- No request: rom_en←0, rom_addr holds, ptr holds, tag stage 0 ← {valid=0}.
- Tag pipeline: ROM_LAT stages, shifted every cycle, no stall. rvalid = valid ? onehot(idx) : 0, taken from the last stage.
- Throughput: one read per cycle total; with k requesters continuously requesting, each is granted exactly once every k cycles.
- N_REQ=1: gnt=req, ptr stays 0.

## Timing
- gnt: same cycle as req (zero latency, combinational).
- rom_en/rom_addr: valid in the cycle after the accepting edge k.
- rvalid/rdata: valid in the cycle after edge k+ROM_LAT. Accept-to-return latency is ROM_LAT+1 cycles, measured as cycles between gnt high and rvalid high (gnt in cycle c → rvalid in cycle c+ROM_LAT+1... counted from the accepting edge: rvalid visible after edge k+ROM_LAT).
- Reset values: ptr=0, rom_en=0, rom_addr=0, all tag stages invalid → rvalid=0. gnt follows req immediately after reset, with ptr=0.
- Reset mid-operation: in-flight reads are discarded, with no rvalid for them. The first read after reset release returns normally.
- Simultaneous request from all: grant order 0,1,2,0,… from reset.
- ptr wrap: a grant to N_REQ-1 sets ptr=0.
- A request arriving while its own previous read is in flight is legal. Returns arrive in issue order.

## Structure
- Shared package (duck_hunt_pkg): clog2 function, default ROM_LAT and DATA_W constants, and the tag struct {valid, idx}.
- Sub-module tag_pipe: parameterised-width shift register, ROM_LAT stages, asynchronous reset to 0, carrying {valid, idx}.
- Arbiter logic (rotate, priority pick, ptr update) and the ROM-side registers stay in the top module.

## Test plan
- Reset, then req=3'b000 for 10 cycles → gnt=0, rom_en=0, rvalid=0 throughout.
- Single request: req=3'b010 for one cycle, addr1=12'h0A5 → gnt=3'b010 the same cycle; rom_en=1 and rom_addr=12'h0A5 next cycle; rvalid=3'b010 with rdata=ROM[0x0A5] ROM_LAT cycles after rom_en.
- All requesting continuously for 9 cycles → gnt sequence 001,010,100 repeated 3×; rvalid follows the same sequence delayed, each with correct data.
- Requester 0 streaming alone, addr incrementing 0x100…0x107 → 8 consecutive grants with no gap; rdata returns ROM[0x100…0x107] in order.
- Fairness after wrap: ptr=2 state, req=3'b101 → grant 100, then 001, then 100.
- Assert rst for 1 cycle with 2 reads in flight → rvalid stays 0 for those reads; ptr=0; the next req=3'b111 grants 001 first.

Source files
------------

// File: rtl/duck_hunt_pkg.sv
// Shared definitions for the duck hunt video pipeline.
//   - clog2: index width helper, never returns less than 1
//   - DEF_ROM_LAT / DEF_DATA_W: default sprite ROM latency and pixel width
//   - tag_t: per-read tracking tag {valid, idx} carried alongside ROM reads
package duck_hunt_pkg;

  localparam int DEF_ROM_LAT = 2;
  localparam int DEF_DATA_W  = 12;

  // Requester index field is fixed-width so the tag type can live here;
  // 8 bits covers up to 256 requesters.
  localparam int TAG_IDX_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

  // Bits needed to hold an index in 0..n-1, minimum 1.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/tag_pipe.sv
// Fixed-depth shift register used to walk read tags alongside the ROM
// read latency. Shifts every cycle, no stall.
//   clk, rst : clock, asynchronous active-high reset (all stages cleared)
//   d        : tag entering stage 0
//   q        : tag leaving the last stage
module tag_pipe #(
  parameter int W      = 9,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM between N_REQ
// pixel-pipeline requesters. One read is accepted per cycle; each read is
// tagged with its requester and the tag is delayed to line up with the
// returned ROM data.
//
// Handshake: req[i] is a level request; gnt[i] is combinational. A read
// from requester i is accepted at the rising edge where req[i] & gnt[i];
// the requester keeps addr stable until that edge and may hold req high
// to stream back-to-back reads.
//
//   clk, rst : clock, asynchronous active-high reset
//   req      : per-requester read request
//   addr     : packed request addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt      : one-hot grant (zero when nothing requests)
//   rom_en   : registered ROM read enable
//   rom_addr : registered ROM address (holds when idle)
//   rom_data : ROM read data
//   rvalid   : one-hot return strobe aligned with rdata
//   rdata    : returned data (rom_data), meaningful while rvalid != 0
module sprite_rom_arbiter
  import duck_hunt_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ROM_LAT = DEF_ROM_LAT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*ADDR_W-1:0]  addr,
  output logic [N_REQ-1:0]         gnt,
  output logic                     rom_en,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [DATA_W-1:0]        rom_data,
  output logic [N_REQ-1:0]         rvalid,
  output logic [DATA_W-1:0]        rdata
);

  localparam int PTR_W = clog2(N_REQ);

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_nxt;
  logic [PTR_W-1:0]  win;
  logic [PTR_W-1:0]  cand_idx;
  logic              found;
  int                cand;
  logic [ADDR_W-1:0] sel_addr;
  tag_t              launch;
  tag_t              tag_q;
  tag_t              tag_out;

  // Priority scan starting at ptr and wrapping; first requester wins.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int j = 0; j < N_REQ; j++) begin
      cand     = (int'(ptr) + j) % N_REQ;
      cand_idx = cand[PTR_W-1:0];
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        win   = cand_idx;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (found) gnt[win] = 1'b1;
  end

  // The winner is always requesting, so a grant is always an accept.
  assign ptr_nxt  = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
  assign sel_addr = addr[win*ADDR_W +: ADDR_W];

  always_comb begin
    launch       = '0;
    launch.valid = found;
    launch.idx   = TAG_IDX_W'(win);
  end

  // tag_q is loaded together with rom_addr, so it marks the read while the
  // ROM samples its address; tag_pipe then covers the ROM_LAT data delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
      tag_q    <= '0;
    end else begin
      rom_en <= found;
      tag_q  <= launch;
      if (found) begin
        rom_addr <= sel_addr;
        ptr      <= ptr_nxt;
      end
    end
  end

  tag_pipe #(
    .W      ($bits(tag_t)),
    .STAGES (ROM_LAT)
  ) u_tag_pipe (
    .clk (clk),
    .rst (rst),
    .d   (tag_q),
    .q   (tag_out)
  );

  always_comb begin
    rvalid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rvalid[i] = tag_out.valid && (tag_out.idx == TAG_IDX_W'(i));
    end
  end

  assign rdata = rom_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
module tb_sprite_rom_arbiter;

  localparam int N   = 3;
  localparam int AW  = 12;
  localparam int DW  = 12;
  localparam int LAT = 2;
  localparam int W   = N + DW;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*AW-1:0] addr;
  logic [N-1:0]    gnt;
  logic            rom_en;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_data;
  logic [N-1:0]    rvalid;
  logic [DW-1:0]   rdata;

  sprite_rom_arbiter #(
    .N_REQ   (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .ROM_LAT (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .addr     (addr),
    .gnt      (gnt),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rvalid   (rvalid),
    .rdata    (rdata)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ROM model ----------------
  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return {a[3:0], a[11:4]} ^ 12'hA5A;
  endfunction

  logic [DW-1:0] rd_pipe [LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= rom_f(rom_addr);
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign rom_data = rd_pipe[LAT-1];

  // ---------------- scoreboard ----------------
  logic [W-1:0]  exp_q[$];
  logic          exp_rom_en;
  logic [AW-1:0] exp_rom_addr;
  int            checks;
  int            errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_clear();
    exp_q.delete();
    for (int i = 0; i < LAT + 1; i++) exp_q.push_back('0);
    exp_rom_en   = 1'b0;
    exp_rom_addr = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_addr(input int i, input logic [AW-1:0] a);
    addr[i*AW +: AW] = a;
  endtask

  // One cycle: check outputs at negedge, log the expected return, advance.
  task automatic cyc(input logic [N-1:0] exp_gnt);
    logic [W-1:0]  e;
    logic [AW-1:0] wa;
    @(negedge clk);
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("rom_en", 32'(rom_en), 32'(exp_rom_en));
    chk("rom_addr", 32'(rom_addr), 32'(exp_rom_addr));
    if (exp_q.size() == LAT + 1) begin
      e = exp_q.pop_front();
      chk("rvalid", 32'(rvalid), 32'(e[W-1:DW]));
      if (e[W-1:DW] != '0) chk("rdata", 32'(rdata), 32'(e[DW-1:0]));
    end
    wa = '0;
    for (int i = 0; i < N; i++) if (exp_gnt[i]) wa = addr[i*AW +: AW];
    exp_q.push_back((exp_gnt != '0) ? {exp_gnt, rom_f(wa)} : '0);
    exp_rom_en = (exp_gnt != '0);
    if (exp_gnt != '0) exp_rom_addr = wa;
    @(posedge clk);
    #1;
  endtask

  // Reset held for one full clock edge; checks the asynchronous clear.
  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    #1;
    chk("rst_rom_en", 32'(rom_en), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_clear();
  endtask

  // ---------------- directed sequence ----------------
  logic [N-1:0] all_seq [9];

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    req    = '0;
    addr   = '0;
    sb_clear();
    #2;
    do_reset();

    // Idle: nothing granted, nothing returned.
    for (int k = 0; k < 10; k++) cyc(3'b000);

    // Single request from requester 1.
    set_addr(1, 12'h0A5);
    req = 3'b010;
    cyc(3'b010);
    req = 3'b000;
    for (int k = 0; k < 4; k++) cyc(3'b000);

    // All requesting from reset: strict 0,1,2 rotation.
    do_reset();
    all_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100,
                3'b001, 3'b010, 3'b100};
    set_addr(0, 12'h200);
    set_addr(1, 12'h310);
    set_addr(2, 12'h420);
    req = 3'b111;
    for (int k = 0; k < 9; k++) begin
      cyc(all_seq[k]);
      for (int i = 0; i < N; i++)
        if (all_seq[k][i]) set_addr(i, addr[i*AW +: AW] + 12'h001);
    end
    req = 3'b000;
    cyc(3'b000);

    // Requester 0 streaming alone, back-to-back.
    req = 3'b001;
    for (int k = 0; k < 8; k++) begin
      set_addr(0, 12'h100 + 12'(k));
      cyc(3'b001);
    end
    req = 3'b000;
    cyc(3'b000);

    // ptr is now 1; one grant to requester 1 moves it to 2.
    set_addr(1, 12'h7E1);
    req = 3'b010;
    cyc(3'b010);
    // Fairness across the wrap: 2, then 0, then 2.
    set_addr(0, 12'h0C3);
    set_addr(2, 12'hFFF);
    req = 3'b101;
    cyc(3'b100);
    cyc(3'b001);
    cyc(3'b100);
    req = 3'b000;
    for (int k = 0; k < 4; k++) cyc(3'b000);

    // Two reads in flight, then reset: neither may return.
    set_addr(0, 12'h055);
    set_addr(1, 12'h066);
    set_addr(2, 12'h077);
    req = 3'b111;
    cyc(3'b001);
    cyc(3'b010);
    do_reset();
    for (int k = 0; k < 3; k++) cyc(3'b000);
    // Pointer back at 0; first read after reset returns normally.
    set_addr(0, 12'h3AB);
    req = 3'b111;
    cyc(3'b001);
    req = 3'b000;
    for (int k = 0; k < 4; k++) cyc(3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
